// File: rtl/sink_pkg.sv
// Shared types for the two-phase sink: capture FSM states and counter width.
package sink_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {
    SINK_IDLE  = 1'b0,
    SINK_STALL = 1'b1
  } sink_state_t;

endpackage

// File: rtl/sink_fifo.sv
// Register FIFO holding captured words; head is read combinationally from the array.
module sink_fifo #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WORD_WIDTH-1:0]    push_data,
  input  logic                     pop,
  output logic [WORD_WIDTH-1:0]    head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]           wr_ptr_reg;
  logic [AW:0]           rd_ptr_reg;
  logic [WORD_WIDTH-1:0] mem_reg [DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop frees the head slot, which is exactly where the write lands.
  assign do_push = push & (~full | do_pop);
  assign head    = mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
        wr_ptr_reg                  <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/two_phase_sink.sv
// Clocked receiver for a two-phase bundled-data channel: synchronizes req, captures into a FIFO, returns ack.
// Optional data checker against EXPECTED is built only when SINK_CHECK_EN is defined.
module two_phase_sink
  import sink_pkg::*;
#(
  parameter int WORD_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EXPECTED    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_in,
  input  logic [WORD_WIDTH-1:0] Data_in,
  output logic                  ack_in,
  output logic                  out_valid,
  output logic [WORD_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      word_count,
  output logic                  err_flag,
  output logic [CNT_W-1:0]      err_count
);

  logic [SYNC_STAGES-1:0]   sync_reg;
  logic                     ack_reg;
  sink_state_t              state_reg;
  logic [CNT_W-1:0]         word_count_reg;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     req_s;
  logic                     pending;
  logic                     pop;
  logic                     space;
  logic                     capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], req_in};
    end
  end

  assign req_s   = sync_reg[SYNC_STAGES-1];
  assign pending = req_s ^ ack_reg;
  assign pop     = ~fifo_empty & out_ready;
  assign space   = ~fifo_full | pop;
  // Data_in is taken raw: the synchronizer delay is the bundling margin.
  assign capture = pending & space;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= SINK_IDLE;
      ack_reg        <= 1'b0;
      word_count_reg <= '0;
    end else begin
      case (state_reg)
        SINK_IDLE: begin
          if (capture) begin
            ack_reg        <= ~ack_reg;
            word_count_reg <= word_count_reg + 1'b1;
          end else if (pending) begin
            state_reg <= SINK_STALL;
          end
        end
        SINK_STALL: begin
          if (capture) begin
            ack_reg        <= ~ack_reg;
            word_count_reg <= word_count_reg + 1'b1;
            state_reg      <= SINK_IDLE;
          end
        end
        default: state_reg <= SINK_IDLE;
      endcase
    end
  end

  sink_fifo #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (Data_in),
    .pop       (pop),
    .head      (out_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ack_in     = ack_reg;
  assign out_valid  = (fifo_count != '0);
  assign word_count = word_count_reg;

`ifdef SINK_CHECK_EN
  logic             err_flag_reg;
  logic [CNT_W-1:0] err_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag_reg  <= 1'b0;
      err_count_reg <= '0;
    end else if (capture && (Data_in != WORD_WIDTH'(EXPECTED))) begin
      err_flag_reg  <= 1'b1;
      err_count_reg <= err_count_reg + 1'b1;
    end
  end

  assign err_flag  = err_flag_reg;
  assign err_count = err_count_reg;
`else
  assign err_flag  = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_two_phase_sink.sv
// Directed bench for two_phase_sink with a behavioural two-phase source; checks via immediate assertions.
module tb_two_phase_sink;
  import sink_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_in;
  logic [31:0] Data_in;
  logic        ack_in;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [15:0] word_count;
  logic        err_flag;
  logic [15:0] err_count;

  int          errors = 0;
  int          checks = 0;

  logic        src_en;
  logic        src_inc;
  logic [31:0] src_val;
  int          sent_n;
  logic [31:0] exp_q[$];
  logic [31:0] sent_word;
  logic [15:0] wrap_exp [3];
  int          guard;

  always #5 clk = ~clk;

  two_phase_sink #(
    .WORD_WIDTH  (32),
    .DEPTH       (4),
    .SYNC_STAGES (2),
    .EXPECTED    (15)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_in     (req_in),
    .Data_in    (Data_in),
    .ack_in     (ack_in),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .word_count (word_count),
    .err_flag   (err_flag),
    .err_count  (err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Source: when no token is pending, present the next word and toggle req together.
  task automatic tick();
    @(negedge clk);
    if (src_en && (req_in === ack_in)) begin
      Data_in = src_val;
      exp_q.push_back(src_val);
      sent_n++;
      if (src_inc) src_val = src_val + 1;
      req_in = ~req_in;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req_in = 1'b0;
    exp_q.delete();
    sent_n = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input string tag, input int exp_cycles);
    int   n;
    logic a0;
    n  = 0;
    a0 = ack_in;
    while ((ack_in === a0) && (n < 20)) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_in    = 1'b0;
    Data_in   = '0;
    out_ready = 1'b1;
    src_en    = 1'b1;
    src_inc   = 1'b0;
    src_val   = 32'd15;
    sent_n    = 0;
    wrap_exp[0] = 16'hFFFF;
    wrap_exp[1] = 16'h0000;
    wrap_exp[2] = 16'h0001;

    // Reset values and first capture latency with a constant-15 source.
    tick();
    tick();
    check("rst_ack", 32'(ack_in), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_wcount", 32'(word_count), 32'd0);
    check("rst_errflag", 32'(err_flag), 32'd0);
    check("rst_errcount", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    wait_ack("first_ack_latency", 3);
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_data", out_data, 32'd15);
    repeat (97) tick();
    check("throughput_100", 32'((word_count >= 16'd32) && (word_count <= 16'd34)), 32'd1);

    // Backpressure: consumer blocked, FIFO fills, FSM stalls, ack frozen.
    out_ready = 1'b0;
    src_inc   = 1'b1;
    src_val   = 32'd100;
    do_reset();
    repeat (40) tick();
    check("stall_wcount", 32'(word_count), 32'd4);
    check("stall_state", 32'(dut.state_reg), 32'(SINK_STALL));
    check("stall_ack", 32'(ack_in), 32'd0);
    check("stall_head", out_data, 32'd100);
    check("stall_fifo_cnt", 32'(dut.u_fifo.count), 32'd4);
    repeat (5) tick();
    check("stall_hold_wcount", 32'(word_count), 32'd4);
    check("stall_hold_ack", 32'(ack_in), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("unstall_wcount", 32'(word_count), 32'd5);
    check("unstall_ack", 32'(ack_in), 32'd1);
    check("unstall_head", out_data, 32'd101);
    check("unstall_fifo_cnt", 32'(dut.u_fifo.count), 32'd4);
    check("unstall_state", 32'(dut.state_reg), 32'(SINK_IDLE));

    // Mid-stream reset with consumer ready.
    out_ready = 1'b1;
    src_val   = 32'd200;
    do_reset();
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_ack", 32'(ack_in), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", out_data, 32'd0);
    check("midrst_wcount", 32'(word_count), 32'd0);
    req_in = 1'b0;
    exp_q.delete();
    sent_word = src_val;
    tick();
    rst_n = 1'b1;
    wait_ack("midrst_restart_latency", 3);
    check("midrst_wcount1", 32'(word_count), 32'd1);
    check("midrst_valid1", 32'(out_valid), 32'd1);
    check("midrst_data1", out_data, sent_word);

    // word_count wrap through 0xFFFF.
    src_en = 1'b0;
    do_reset();
    tick();
    force dut.word_count_reg = 16'hFFFE;
    tick();
    release dut.word_count_reg;
    tick();
    check("wrap_preload", 32'(word_count), 32'h0000FFFE);
    for (int i = 0; i < 3; i++) begin
      src_en = 1'b1;
      tick();
      src_en = 1'b0;
      repeat (5) tick();
      check($sformatf("wrap_step%0d", i), 32'(word_count), 32'(wrap_exp[i]));
    end

    // Data checker.
    src_en  = 1'b1;
    src_inc = 1'b0;
    src_val = 32'd14;
    do_reset();
`ifdef SINK_CHECK_EN
    wait_ack("chk_ack_latency", 3);
    tick();
    check("chk_errflag1", 32'(err_flag), 32'd1);
    check("chk_errcount1", 32'(err_count), 32'd1);
    repeat (6) tick();
    check("chk_errcount3", 32'(err_count), 32'd3);
    check("chk_errflag3", 32'(err_flag), 32'd1);
    src_val = 32'd15;
    do_reset();
    repeat (12) tick();
    check("chk_ok_wcount", 32'(word_count), 32'd4);
    check("chk_ok_errcount", 32'(err_count), 32'd0);
    check("chk_ok_errflag", 32'(err_flag), 32'd0);
`else
    repeat (12) tick();
    check("nochk_wcount", 32'(word_count), 32'd4);
    check("nochk_errflag", 32'(err_flag), 32'd0);
    check("nochk_errcount", 32'(err_count), 32'd0);
`endif

    // Random backpressure over 1000 tokens against an in-order scoreboard.
    src_inc   = 1'b1;
    src_val   = 32'd1000;
    out_ready = 1'b1;
    do_reset();
    guard = 0;
    while (((sent_n < 1000) || (exp_q.size() > 0)) && (guard < 20000)) begin
      src_en = (sent_n < 1000);
      tick();
      guard++;
      out_ready = 1'($urandom_range(0, 1));
      check("fifo_bound", 32'(dut.u_fifo.count <= 3'd4), 32'd1);
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("sb_word", out_data, exp_q.pop_front());
      end
    end
    check("random_drained", 32'(exp_q.size()), 32'd0);
    check("random_sent", 32'(sent_n), 32'd1000);
    check("random_wcount", 32'(word_count), 32'd1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/two_phase_sink.md
# two_phase_sink

Clocked receiving end of the two-phase (transition-signalled) bundled-data channel driven by the asynchronous `Source` block. A token is pending whenever `req_in` differs from `ack_in`. The block synchronizes `req_in` into the `clk` domain and captures the bundled word into a small FIFO. It then toggles `ack_in` to return the phase, and presents the words on a synchronous valid/ready port. It terminates every MouseTrap pipeline under test in simulation and on FPGA.

## Interface
- `WORD_WIDTH`, 32: width of the bundled data word.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2: flops on the `req_in` synchronizer; ≥2.
- `EXPECTED`, 15: reference word for the checker (only used with `SINK_CHECK_EN`).

Ports:
- `clk` input 1: sole clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_in` input 1: two-phase request from the source; asynchronous to `clk`.
- `Data_in` input WORD_WIDTH: bundled data, stable while a token is pending.
- `ack_in` output 1: two-phase acknowledge back to the source; registered.
- `out_valid` output 1: FIFO non-empty.
- `out_data` output WORD_WIDTH: FIFO head.
- `out_ready` input 1: consumer accepts the head.
- `word_count` output 16: total words captured since reset.
- `err_flag` output 1: sticky data-mismatch flag.
- `err_count` output 16: number of mismatching words.

## Operation
- Synchronizer: `req_in` passes through SYNC_STAGES flops, giving `req_s`. `pending = req_s ^ ack_in`.
- The capture controller is a two-state FSM:
  - IDLE:
    - `pending` with space available: write `Data_in` into the FIFO, toggle `ack_in`, increment `word_count`. Stay in IDLE.
    - `pending` with the FIFO full: go to STALL.
  - STALL:
    - Space available: same write/toggle/increment actions as in IDLE, then return to IDLE.
    - Otherwise hold; `ack_in` is not toggled.
- Space available means count < DEPTH, or the FIFO is full and a pop occurs in the same cycle.
- `Data_in` is sampled raw, without synchronization. The synchronizer delay of ≥2 cycles is the bundling margin, because the source changes data together with req.
- After `ack_in` toggles, `req_s` still holds the old phase, so `pending` drops the next cycle. No token is captured twice.
- Output: `out_valid = count != 0` and `out_data = mem[rd_ptr]`. A pop occurs when `out_valid & out_ready`.
- A simultaneous push and pop keeps count unchanged. Pointers wrap modulo DEPTH.
- `word_count` and `err_count` wrap 0xFFFF→0x0000.
- Reset mid-operation flushes the FIFO and clears all state and counters. It is legal at any time.
  - `ack_in` returns to 0, so the `Source` block drives `req_in=1`.
  - The first token after reset is seen after SYNC_STAGES cycles.

## Timing
- Reset values: `ack_in`=0, `out_valid`=0, `out_data`=0, `word_count`=0, `err_flag`=0, `err_count`=0. Synchronizer flops = 0. FSM in IDLE.
- Latency: `req_in` edge → `ack_in` toggle takes SYNC_STAGES+1 `clk` edges when there is space.
- The captured word is visible on `out_valid` at the edge after capture.
- Throughput with the `Source` block: one word per SYNC_STAGES+1 cycles.
- FIFO full for N cycles stalls `ack_in` for N cycles. Backpressure propagates upstream through the handshake.
- `ack_in` changes only on `clk` rising edges or on reset assertion.

## Configuration
- `SINK_CHECK_EN` defined:
  - Each captured word is compared with `EXPECTED` in the capture cycle.
  - On a mismatch, `err_count` increments and `err_flag` sets; both are visible the next cycle.
  - `err_flag` clears only on reset.
- `SINK_CHECK_EN` undefined: no comparator or error registers are built, and `err_flag`/`err_count` are tied to 0.

## Structure
- Package `sink_pkg`: FSM state enum (`SINK_IDLE`, `SINK_STALL`) and the counter width localparam `CNT_W` = 16.
- Sub-module `sink_fifo`: parameterized WORD_WIDTH × DEPTH register FIFO.
  - Ports: push, push_data, pop, head, count, full, empty.
  - Pointers are log2(DEPTH)+1 bits wide.
- Top level holds the synchronizer, FSM, `ack_in` register, counters and checker.

## Test plan
- Reset release with the `Source` block (VALUE=15) attached and `out_ready`=1:
  - `ack_in` first toggles 3 cycles after reset release, and `out_data`=15 with `out_valid`.
  - After 100 cycles, `word_count` is 33 ±1.
- `out_ready`=0 with DEPTH=4: exactly 4 words captured, FSM in STALL, `ack_in` frozen.
  - Raise `out_ready` for one cycle: the 5th word is captured in that same cycle.
- Hold `out_ready`=1 and assert `rst_n` mid-stream:
  - All outputs return to reset values immediately.
  - The FIFO is empty, and capture restarts SYNC_STAGES+1 cycles after release.
- Preload `word_count` to 0xFFFE by force, then send 3 tokens: the count reads 0xFFFF, 0x0000, 0x0001.
- `SINK_CHECK_EN` with `EXPECTED`=15 and source VALUE=14:
  - Each capture increments `err_count`, and `err_flag`=1 after the first capture.
  - With VALUE=15, `err_count` stays 0.
- Random `out_ready` (50%) over 1000 tokens: no duplicate or lost words, and the FIFO count never exceeds 4.
